// File: rtl/nanci_inject.sv
// Per-PE mesh packet injector: a request FIFO drained one packet per sort round, with a null packet for empty rounds.
// Optional statistics counters are enabled with `define NANCI_INJECT_STATS_EN.
module nanci_inject #(
  parameter int N           = 4,
  parameter int ADDR_WIDTH  = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int SORT_CYCLES = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int PE_ID       = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_data,
  output logic [ADDR_WIDTH+DATA_WIDTH:0]   pkt_out,
  output logic                             round_start,
  output logic                             idle,
  output logic                             overflow
`ifdef NANCI_INJECT_STATS_EN
  ,
  output logic [15:0]                      stat_inj,
  output logic [15:0]                      stat_null,
  output logic [15:0]                      stat_stall
`endif
);

  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH) + 1;
  localparam int RW = (SORT_CYCLES > 1) ? $clog2(SORT_CYCLES) : 1;

  if (ADDR_WIDTH < $clog2(N) || PE_ID >= N) begin : g_param_check
    $error("nanci_inject: ADDR_WIDTH too small for N or PE_ID out of range");
  end

  typedef enum logic {ST_LOAD, ST_HOLD} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   round_cnt_q, round_cnt_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [EW:0]     pkt_q, pkt_d;
  logic            overflow_q, overflow_d;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];

  logic full, empty, push, pop, load;

  always_comb begin
    full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    empty = (wr_ptr_q == rd_ptr_q);
    load  = (state_q == ST_LOAD);
    // Ready comes from the registered full flag only; a same-cycle pop never frees a slot early.
    push  = req_valid && !full;
    pop   = load && !empty;

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);

    if (SORT_CYCLES == 1 || round_cnt_q == RW'(SORT_CYCLES - 1)) begin
      round_cnt_d = '0;
    end else begin
      round_cnt_d = round_cnt_q + RW'(1);
    end
    state_d = (round_cnt_d == '0) ? ST_LOAD : ST_HOLD;

    pkt_d = pkt_q;
    if (load) begin
      pkt_d = empty ? '0 : {1'b1, mem_q[rd_ptr_q[PW-2:0]]};
    end

    overflow_d = overflow_q | (req_valid && full);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      round_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_cnt_q <= round_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_q       <= pkt_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage is deliberately unreset; validity is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PW-2:0]] <= {req_addr, req_data};
    end
  end

  assign req_ready   = !full;
  assign pkt_out     = pkt_q;
  assign round_start = (round_cnt_q == '0);
  assign idle        = empty && !pkt_q[EW];
  assign overflow    = overflow_q;

`ifdef NANCI_INJECT_STATS_EN
  logic [15:0] inj_count_q, inj_count_d;
  logic [15:0] null_count_q, null_count_d;
  logic [15:0] stall_count_q, stall_count_d;

  always_comb begin
    inj_count_d   = inj_count_q;
    null_count_d  = null_count_q;
    stall_count_d = stall_count_q;
    if (pop && inj_count_q != 16'hFFFF)                   inj_count_d   = inj_count_q + 16'd1;
    if (load && empty && null_count_q != 16'hFFFF)        null_count_d  = null_count_q + 16'd1;
    if (req_valid && full && stall_count_q != 16'hFFFF)   stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_count_q   <= '0;
      null_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      inj_count_q   <= inj_count_d;
      null_count_q  <= null_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stat_inj   = inj_count_q;
  assign stat_null  = null_count_q;
  assign stat_stall = stall_count_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && req_valid && full) $display("nanci_inject PE%0d: overflow, request dropped", PE_ID);
  end
`endif
`else
`endif

endmodule

// File: tb/tb_nanci_inject.sv
// Directed, table-driven bench for nanci_inject (N=4, SORT_CYCLES=4, FIFO_DEPTH=4, default build).
module tb_nanci_inject;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_addr;
  logic [31:0] req_data;
  logic [34:0] pkt_out;
  logic        round_start;
  logic        idle;
  logic        overflow;

  int n_pass  = 0;
  int n_total = 0;
  int kk;

  typedef struct {
    logic        vld;
    logic [1:0]  addr;
    logic [31:0] data;
    logic [34:0] pkt;
    logic        rdy;
    logic        rs;
    logic        idl;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  nanci_inject #(
    .N(4), .ADDR_WIDTH(2), .DATA_WIDTH(32), .SORT_CYCLES(4), .FIFO_DEPTH(4), .PE_ID(0)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
    .pkt_out(pkt_out), .round_start(round_start), .idle(idle), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] pk(input logic [1:0] a, input logic [31:0] d);
    return {1'b1, a, d};
  endfunction

  // Round start follows the edge count since release: high after edges 4, 8, 12, ...
  task automatic add(input logic v, input logic [1:0] a, input logic [31:0] d,
                     input logic [34:0] p, input logic r, input logic i, input logic o);
    vec_t t;
    t.vld = v; t.addr = a; t.data = d; t.pkt = p;
    t.rdy = r; t.rs = (kk % 4 == 0); t.idl = i; t.ovf = o;
    vecs.push_back(t);
    kk++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Entered at a negedge; drives, lets one rising edge pass, checks, returns at the next negedge.
  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      req_valid = vecs[i].vld;
      req_addr  = vecs[i].addr;
      req_data  = vecs[i].data;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d {pkt,rdy,rs,idle,ovf}", i),
            64'({pkt_out, req_ready, round_start, idle, overflow}),
            64'({vecs[i].pkt, vecs[i].rdy, vecs[i].rs, vecs[i].idl, vecs[i].ovf}));
      $display("vec%0d valid=%0b addr=%0d data=%h -> pkt=%h rdy=%0b rs=%0b idle=%0b ovf=%0b",
               i, vecs[i].vld, vecs[i].addr, vecs[i].data, pkt_out, req_ready, round_start, idle, overflow);
      @(negedge clk);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " pkt_out"},     64'(pkt_out),     64'(0));
    check({tag, " req_ready"},   64'(req_ready),   64'(1));
    check({tag, " round_start"}, 64'(round_start), 64'(1));
    check({tag, " idle"},        64'(idle),        64'(1));
    check({tag, " overflow"},    64'(overflow),    64'(0));
  endtask

  int seg1_end;

  initial begin
    // Segment 1: edges 1..46 after the first reset release.
    kk = 1;
    for (int k = 1; k <= 11; k++) add(0, 0, 0, '0, 1, 1, 0);
    add(1, 2'd3, 32'h0, '0, 1, 0, 0);                           // lands one edge before LOAD edge 13
    for (int k = 13; k <= 16; k++) add(0, 0, 0, pk(2'd3, 32'h0), 1, 0, 0);
    for (int k = 17; k <= 20; k++) add(0, 0, 0, '0, 1, 1, 0);
    add(1, 2'd0, 32'd3, '0, 1, 0, 0);                           // edge 21: push on LOAD into empty FIFO -> null round
    add(1, 2'd1, 32'd2, '0, 1, 0, 0);
    add(1, 2'd2, 32'd1, '0, 1, 0, 0);
    add(1, 2'd3, 32'd0, '0, 0, 0, 0);                           // fourth entry: full
    add(1, 2'd2, 32'hDEAD, pk(2'd0, 32'd3), 1, 0, 1);           // push while full: dropped, overflow
    for (int k = 26; k <= 28; k++) add(0, 0, 0, pk(2'd0, 32'd3), 1, 0, 1);
    for (int k = 29; k <= 32; k++) add(0, 0, 0, pk(2'd1, 32'd2), 1, 0, 1);
    for (int k = 33; k <= 36; k++) add(0, 0, 0, pk(2'd2, 32'd1), 1, 0, 1);
    for (int k = 37; k <= 40; k++) add(0, 0, 0, pk(2'd3, 32'd0), 1, 0, 1);
    add(0, 0, 0, '0, 1, 1, 1);
    add(1, 2'd1, 32'h11, '0, 1, 0, 1);
    add(1, 2'd2, 32'h22, '0, 1, 0, 1);
    add(1, 2'd3, 32'h33, '0, 1, 0, 1);
    add(0, 0, 0, pk(2'd1, 32'h11), 1, 0, 1);
    add(0, 0, 0, pk(2'd1, 32'h11), 1, 0, 1);                    // round_cnt now 2, two entries queued
    seg1_end = vecs.size() - 1;

    // Segment 2: after the mid-round reset; stale entries must never appear.
    kk = 1;
    for (int j = 1; j <= 9; j++) add(0, 0, 0, '0, 1, 1, 0);
    add(1, 2'd2, 32'h55, '0, 1, 0, 0);
    add(0, 0, 0, '0, 1, 0, 0);
    add(0, 0, 0, '0, 1, 0, 0);
    for (int j = 13; j <= 16; j++) add(0, 0, 0, pk(2'd2, 32'h55), 1, 0, 0);
    add(0, 0, 0, '0, 1, 1, 0);

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0;
    #1;
    check_reset_state("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run(0, seg1_end);

    // Asynchronous reset mid-round: outputs must clear before any clock edge.
    rst = 1'b1;
    #1;
    check_reset_state("async_reset");
    @(posedge clk);
    #1;
    check("reset_held pkt_out", 64'(pkt_out), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    run(seg1_end + 1, vecs.size() - 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/nanci_inject.md
# nanci_inject

Per-PE packet injector that sits directly upstream of a mesh PE's sort port. It buffers local write requests (destination PE address plus data) in a small FIFO. On a fixed round schedule of SORT_CYCLES cycles it presents exactly one packet per round to the mesh: the FIFO head, or a null packet when the FIFO is empty. Every PE in the mesh must contribute a packet each round so the sorting network stays lock-stepped.

## Interface
- N, 4, number of PEs in the mesh
- ADDR_WIDTH, 2, destination PE address width (clog2(N))
- DATA_WIDTH, 32, payload width
- SORT_CYCLES, 4, cycles per mesh sort round (≥1)
- FIFO_DEPTH, 4, request FIFO entries (power of two, ≥2)
- PE_ID, 0, this PE's index; reported only in stats

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  local write request present
- req_ready  out  1  FIFO can accept; equals !full
- req_addr  in  ADDR_WIDTH  destination PE
- req_data  in  DATA_WIDTH  payload
- pkt_out  out  1+ADDR_WIDTH+DATA_WIDTH  packet to mesh, {valid, addr, data}
- round_start  out  1  high during round cycle 0
- idle  out  1  FIFO empty and pkt_out valid bit 0
- overflow  out  1  sticky: req_valid seen while full

## Operation
- FIFO push occurs when req_valid && req_ready.
- req_ready depends only on the registered full flag. It is never raised by a same-cycle pop, so there is no combinational path from round logic to req_ready.
- round_cnt runs 0..SORT_CYCLES-1 and wraps to 0. With SORT_CYCLES=1 it is held at 0.
- States:
  - LOAD (round_cnt==0): at the clock edge, if the FIFO is non-empty, pop the head and set pkt_out={1,addr,data}. Otherwise set pkt_out to all zeros (null packet).
  - HOLD (round_cnt 1..S-1): pkt_out holds its value.
  - Transitions: LOAD→HOLD, HOLD→HOLD until round_cnt==S-1, then →LOAD. With S=1 the block stays in LOAD every cycle.
- Simultaneous push and pop in LOAD: both occur. Occupancy is unchanged.
- Push into an empty FIFO in the LOAD cycle: no bypass. That round injects a null packet, and the request goes out next round.
- Push while full: the request is dropped by the FIFO and overflow is set. It stays set until reset.
- Ordering: strict FIFO. No reordering by address.
- Pointers: log2(FIFO_DEPTH)+1 bits each, with an extra wrap bit. full = MSBs differ and low bits equal. empty = pointers equal.

## Timing
- Reset values:
  - pkt_out=0 (null)
  - round_cnt=0
  - FIFO empty
  - req_ready=1
  - round_start=1
  - idle=1
  - overflow=0
- After rst falls, the first rising edge is a LOAD edge. Subsequent LOAD edges follow every SORT_CYCLES cycles.
- Latency from push to pkt_out: minimum 1 edge, when the push lands before the next LOAD edge. Maximum is SORT_CYCLES×(occupancy+1) edges.
- round_start is combinational from round_cnt==0 and is glitch-free (register-decoded). The mesh samples pkt_out anywhere within a round.
- Reset asserted mid-round:
  - All state clears immediately, without waiting for a clock edge.
  - Queued requests are lost.
  - The round realigns to cycle 0 on release.
- Throughput: at most one packet per SORT_CYCLES cycles.

## Configuration
- NANCI_INJECT_STATS_EN defined:
  - Adds 16-bit saturating counters: inj_count (valid packets injected), null_count (null rounds), stall_count (cycles with req_valid && !req_ready).
  - Exposed as output ports stat_inj, stat_null, stat_stall.
  - All counters reset to 0.
  - A simulation-only $display on overflow, printing PE_ID.
- Not defined: the stat ports and counters are absent. Functional behaviour is otherwise identical.

## Test plan
All scenarios use N=4, SORT_CYCLES=4, FIFO_DEPTH=4.
- Reset then idle for 3 rounds → pkt_out=0 every cycle, round_start high on cycles 0, 4 and 8 after release, idle=1.
- Push {addr=3, data=0x0} one cycle before a LOAD edge → pkt_out=0x3_00000000 with valid=1 after that edge, held 4 cycles, then null; idle returns to 1.
- Push 4 requests back-to-back (addr 0..3, data 3..0) → req_ready low after the 4th push. Packets leave in order over 4 consecutive rounds; req_ready rises after the first LOAD pop.
- Push a 5th request while full → overflow=1 and stays 1; the request is not injected. With STATS_EN, stat_stall increments by 1.
- Push exactly on a LOAD cycle with an empty FIFO → that round injects null; the next round injects the request.
- Assert rst for 1 cycle at round_cnt=2 with 2 queued entries → pkt_out=0 at once, FIFO empty, first LOAD at the first edge after release, no stale packet emitted.
